// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU background/window fetch path.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE, MAP_A, MAP_D, LO_A, LO_D, HI_A, HI_D, PUSH
  } fetch_state_e;

  typedef enum logic [1:0] {
    PH_MAP, PH_LO, PH_HI
  } fetch_phase_e;

  localparam logic [12:0] VRAM_MAP0        = 13'h1800;
  localparam logic [12:0] VRAM_MAP1        = 13'h1C00;
  localparam logic [12:0] TILE_SIGNED_BASE = 13'h1000;
  localparam int          PIX_GROUP_W      = 16;

  // Pixel i = {hi[7-i], lo[7-i]}, leftmost pixel in the top bits.
  function automatic logic [PIX_GROUP_W-1:0] decode_group(input logic [7:0] lo,
                                                          input logic [7:0] hi);
    logic [PIX_GROUP_W-1:0] g;
    g = '0;
    for (int i = 0; i < 8; i++) begin
      g[15-2*i -: 2] = {hi[7-i], lo[7-i]};
    end
    return g;
  endfunction

endpackage

// File: rtl/ppu_vram_addr_gen.sv
// Combinational VRAM address for the tile-map read or one of the two bitplane reads.
module ppu_vram_addr_gen
  import ppu_pkg::*;
(
  input  logic         win_i,
  input  logic [7:0]   y_i,
  input  logic [4:0]   col_i,
  input  logic [7:0]   tile_no_i,
  input  logic         map_sel_bg_i,
  input  logic         map_sel_win_i,
  input  logic         data_sel_i,
  input  fetch_phase_e phase_i,
  output logic [12:0]  addr_o
);

  logic [12:0] map_base;
  logic [12:0] data_base;

  always_comb begin
    map_base = (win_i ? map_sel_win_i : map_sel_bg_i) ? VRAM_MAP1 : VRAM_MAP0;
    // Signed mode: tile number is two's complement around the 0x1000 base.
    if (data_sel_i) data_base = {1'b0, tile_no_i, 4'b0000};
    else            data_base = TILE_SIGNED_BASE + {tile_no_i[7], tile_no_i, 4'b0000};
    if (phase_i == PH_MAP) addr_o = map_base | {3'b000, y_i[7:3], col_i};
    else                   addr_o = data_base | {9'd0, y_i[2:0], phase_i == PH_HI};
  end

endmodule

// File: rtl/ppu_bg_fetcher.sv
// BG/window tile fetcher: map read, two bitplane reads, then one 8-pixel group push.
module ppu_bg_fetcher
  import ppu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   win_start,
  input  logic                   pause,
  input  logic [7:0]             ly,
  input  logic [7:0]             scx,
  input  logic [7:0]             scy,
  input  logic [7:0]             win_line,
  input  logic                   map_sel_bg,
  input  logic                   map_sel_win,
  input  logic                   data_sel,
  output logic [12:0]            vram_a,
  output logic                   vram_rd,
  input  logic [7:0]             vram_d,
  output logic                   pix_valid,
  output logic [PIX_GROUP_W-1:0] pix_data,
  input  logic                   pix_ready,
  output logic                   busy
);

  fetch_state_e state_q;
  logic         win_q;
  logic [4:0]   tile_x_q;
  logic [7:0]   tile_no_q;
  logic [7:0]   lo_q;
  logic [7:0]   hi_q;
  logic [12:0]  vram_a_q;

  logic         ag_win;
  logic [4:0]   ag_tile_x;
  logic [7:0]   ag_tile_no;
  logic [7:0]   ag_y;
  logic [4:0]   ag_col;
  fetch_phase_e ag_phase;
  logic [12:0]  ag_addr;

  // Address of the read issued in the *next* *_A state, so vram_a can be registered.
  always_comb begin
    ag_win     = win_q;
    ag_tile_x  = tile_x_q;
    ag_tile_no = tile_no_q;
    ag_phase   = PH_MAP;
    if (start) begin
      ag_win    = 1'b0;
      ag_tile_x = '0;
    end else if (win_start) begin
      ag_win    = 1'b1;
      ag_tile_x = '0;
    end else begin
      case (state_q)
        MAP_D: begin
          ag_phase   = PH_LO;
          ag_tile_no = vram_d;
        end
        LO_D:    ag_phase  = PH_HI;
        PUSH:    ag_tile_x = tile_x_q + 5'd1;
        default: ;
      endcase
    end
    ag_y   = ag_win ? win_line : ly + scy;
    ag_col = ag_win ? ag_tile_x : scx[7:3] + ag_tile_x;
  end

  ppu_vram_addr_gen u_addr_gen (
    .win_i         (ag_win),
    .y_i           (ag_y),
    .col_i         (ag_col),
    .tile_no_i     (ag_tile_no),
    .map_sel_bg_i  (map_sel_bg),
    .map_sel_win_i (map_sel_win),
    .data_sel_i    (data_sel),
    .phase_i       (ag_phase),
    .addr_o        (ag_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      tile_x_q  <= '0;
      tile_no_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      vram_a_q  <= '0;
    end else if (stop) begin
      state_q <= IDLE;
    end else if (start) begin
      state_q  <= MAP_A;
      win_q    <= 1'b0;
      tile_x_q <= '0;
      vram_a_q <= ag_addr;
    end else if (win_start && state_q != IDLE) begin
      state_q  <= MAP_A;
      win_q    <= 1'b1;
      tile_x_q <= '0;
      vram_a_q <= ag_addr;
    end else begin
      // *_D states never stall: their read is already in flight.
      case (state_q)
        MAP_A: if (!pause) state_q <= MAP_D;
        MAP_D: begin
          tile_no_q <= vram_d;
          vram_a_q  <= ag_addr;
          state_q   <= LO_A;
        end
        LO_A: if (!pause) state_q <= LO_D;
        LO_D: begin
          lo_q     <= vram_d;
          vram_a_q <= ag_addr;
          state_q  <= HI_A;
        end
        HI_A: if (!pause) state_q <= HI_D;
        HI_D: begin
          hi_q    <= vram_d;
          state_q <= PUSH;
        end
        PUSH: if (pix_ready && !pause) begin
          tile_x_q <= ag_tile_x;
          vram_a_q <= ag_addr;
          state_q  <= MAP_A;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vram_a    = vram_a_q;
  assign vram_rd   = (state_q inside {MAP_A, LO_A, HI_A}) & ~pause;
  assign pix_valid = (state_q == PUSH) & ~pause;
  assign pix_data  = decode_group(lo_q, hi_q);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Scoreboard bench for ppu_bg_fetcher: expected reads/groups queued at stimulus, popped by a monitor.
module tb_ppu_bg_fetcher;

  logic        clk = 1'b0;
  logic        rst, start, stop, win_start, pause;
  logic [7:0]  ly, scx, scy, win_line;
  logic        map_sel_bg, map_sel_win, data_sel;
  logic [12:0] vram_a;
  logic        vram_rd;
  logic [7:0]  vram_d = '0;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        busy;

  logic [7:0]  mem [0:8191];
  logic [12:0] rd_q[$];
  logic [15:0] pix_q[$];
  logic [12:0] mon_a;
  logic [15:0] mon_p;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ppu_bg_fetcher dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .win_start(win_start), .pause(pause),
    .ly(ly), .scx(scx), .scy(scy), .win_line(win_line),
    .map_sel_bg(map_sel_bg), .map_sel_win(map_sel_win), .data_sel(data_sel),
    .vram_a(vram_a), .vram_rd(vram_rd), .vram_d(vram_d),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready), .busy(busy)
  );

  // VRAM: data appears the cycle after the strobe.
  always @(posedge clk) if (vram_rd) vram_d <= mem[vram_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=%0h required=none", name, act);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (vram_rd) begin
        if (rd_q.size() == 0) fail_note("unexpected_read", 32'(vram_a));
        else begin
          mon_a = rd_q.pop_front();
          check("vram_a", 32'(vram_a), 32'(mon_a));
        end
      end
      if (pix_valid && pix_ready) begin
        if (pix_q.size() == 0) fail_note("unexpected_push", 32'(pix_data));
        else begin
          mon_p = pix_q.pop_front();
          check("pix_data", 32'(pix_data), 32'(mon_p));
        end
      end
    end
  end

  // Reference model: line geometry from the scroll/window registers.
  function automatic logic [7:0] line_y(input bit w);
    return w ? win_line : 8'(int'(ly) + int'(scy));
  endfunction

  function automatic logic [12:0] map_addr(input bit w, input int k);
    int y, col, base;
    y    = int'(line_y(w));
    col  = w ? k % 32 : (int'(scx) / 8 + k) % 32;
    base = (w ? map_sel_win : map_sel_bg) ? 'h1C00 : 'h1800;
    return 13'(base + (y / 8) * 32 + col);
  endfunction

  function automatic logic [12:0] data_addr(input logic [7:0] tn, input bit w, input int hi);
    int t;
    t = int'(tn);
    if (!data_sel && t >= 128) t = t - 256;
    return 13'((data_sel ? 0 : 'h1000) + t * 16 + (int'(line_y(w)) % 8) * 2 + hi);
  endfunction

  function automatic logic [15:0] group(input logic [7:0] lo, input logic [7:0] hi);
    int g;
    g = 0;
    for (int i = 0; i < 8; i++)
      g += (2 * ((int'(hi) >> (7 - i)) & 1) + ((int'(lo) >> (7 - i)) & 1)) << (2 * (7 - i));
    return 16'(g);
  endfunction

  task automatic expect_tile(input bit w, input int k, input bit with_pix);
    logic [12:0] ma, la, ha;
    ma = map_addr(w, k);
    la = data_addr(mem[ma], w, 0);
    ha = data_addr(mem[ma], w, 1);
    rd_q.push_back(ma);
    rd_q.push_back(la);
    rd_q.push_back(ha);
    if (with_pix) pix_q.push_back(group(mem[la], mem[ha]));
  endtask

  task automatic expect_map(input bit w, input int k);
    rd_q.push_back(map_addr(w, k));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vram_a"}, 32'(vram_a), 0);
    check({tag, "_vram_rd"}, 32'(vram_rd), 0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check({tag, "_pix_data"}, 32'(pix_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Run until every expected group and read is consumed, then stop the line.
  task automatic finish_line(input bit rnd);
    int budget;
    budget = 3000;
    while (budget > 0) begin
      if (pix_q.size() == 0) begin
        pause     = 1'b0;
        pix_ready = 1'b1;
        if (rd_q.size() == 0) break;
      end else if (rnd) begin
        pause     = ($urandom_range(0, 3) == 0);
        pix_ready = ($urandom_range(0, 3) != 0);
      end
      tick;
      budget--;
    end
    if (budget == 0) begin
      fail_note("line_timeout", 32'(pix_q.size() + rd_q.size()));
      rd_q.delete();
      pix_q.delete();
    end
    pause     = 1'b0;
    pix_ready = 1'b1;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    check("busy_after_stop", 32'(busy), 0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    int n, reads;
    bit w;
    rst = 1'b1; start = 1'b0; stop = 1'b0; win_start = 1'b0; pause = 1'b0; pix_ready = 1'b1;
    ly = '0; scx = '0; scy = '0; win_line = '0;
    map_sel_bg = 1'b0; map_sel_win = 1'b0; data_sel = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    tick;
    tick;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick;

    // Basic fetch and start latency
    mem[13'h1800] = 8'h05; mem[13'h0050] = 8'hF0; mem[13'h0051] = 8'h0F;
    expect_tile(0, 0, 1);
    expect_map(0, 1);
    pulse_start;
    n = 1;
    while (!pix_valid && n < 20) begin tick; n++; end
    check("start_latency", 32'(n), 7);
    check("basic_pix", 32'(pix_data), 32'h55AA);
    finish_line(0);

    // Signed tile data
    data_sel = 1'b0; ly = 8'd3;
    mem[13'h1800] = 8'h80; mem[13'h1801] = 8'h00;
    expect_tile(0, 0, 1);
    expect_tile(0, 1, 1);
    expect_map(0, 2);
    pulse_start;
    finish_line(1);

    // Scroll wrap
    data_sel = 1'b1; scx = 8'hF8; scy = 8'h10; ly = 8'hF5;
    for (int k = 0; k < 3; k++) expect_tile(0, k, 1);
    expect_map(0, 3);
    pulse_start;
    finish_line(1);

    // Pause in LO_D, then backpressure on the pushed group
    scx = '0; scy = '0; ly = '0;
    expect_tile(0, 0, 1);
    expect_tile(0, 1, 1);
    expect_map(0, 2);
    pulse_start;
    tick; tick; tick;
    pause = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      check("pause_rd", 32'(vram_rd), 0);
      check("pause_addr", 32'(vram_a), 32'(data_addr(mem[map_addr(0, 0)], 0, 1)));
      tick;
    end
    pause = 1'b0;
    n = 0;
    while (!pix_valid && n < 20) begin tick; n++; end
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(pix_valid), 1);
      check("bp_hold_data", 32'(pix_data), 32'(pix_q[0]));
      check("bp_no_read", 32'(vram_rd), 0);
      tick;
    end
    pix_ready = 1'b1;
    finish_line(0);

    // Window switch during HI_A
    ly = 8'h20; scx = 8'h10; map_sel_win = 1'b1; win_line = 8'd9;
    expect_tile(0, 0, 0);
    expect_tile(1, 0, 1);
    expect_tile(1, 1, 1);
    expect_map(1, 2);
    pulse_start;
    tick; tick; tick; tick;
    win_start = 1'b1;
    tick;
    win_start = 1'b0;
    check("win_map_addr", 32'(vram_a), 32'h1C20);
    check("win_rd", 32'(vram_rd), 1);
    finish_line(1);

    // Stop in LO_D: idle until the next start
    ly = '0; scx = '0; map_sel_win = 1'b0;
    rd_q.push_back(map_addr(0, 0));
    rd_q.push_back(data_addr(mem[map_addr(0, 0)], 0, 0));
    pulse_start;
    tick; tick; tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    check("stop_busy", 32'(busy), 0);
    check("stop_valid", 32'(pix_valid), 0);
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      if (vram_rd) reads++;
      tick;
    end
    check("idle_reads", 32'(reads), 0);
    check("stop_drained", 32'(rd_q.size()), 0);

    // Reset while holding in PUSH
    expect_tile(0, 0, 1);
    expect_map(0, 1);
    pulse_start;
    n = 0;
    while (!pix_valid && n < 20) begin tick; n++; end
    pix_ready = 1'b0;
    rst = 1'b1;
    tick;
    check_reset_outputs("rst_push");
    rst = 1'b0;
    pix_ready = 1'b1;
    rd_q.delete();
    pix_q.delete();
    tick;

    // Randomised lines, BG and window, including a tile_x wrap past 31
    for (int ln = 0; ln < 8; ln++) begin
      scx = 8'($urandom); scy = 8'($urandom); ly = 8'($urandom); win_line = 8'($urandom);
      map_sel_bg = 1'($urandom); map_sel_win = 1'($urandom); data_sel = 1'($urandom);
      w = (ln == 1) ? 1'b1 : 1'($urandom);
      n = (ln < 2) ? 34 : $urandom_range(1, 5);
      if (w) expect_map(0, 0);
      for (int k = 0; k < n; k++) expect_tile(w, k, 1);
      expect_map(w, n);
      pulse_start;
      if (w) begin
        win_start = 1'b1;
        tick;
        win_start = 1'b0;
      end
      finish_line(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
